// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: D-stage control-flow decision and I-mem read data in, fetch PC, instruction and counters out.
interface pc_fetch_if;
    logic        WE;
    logic [2:0]  pcSrc;
    logic [31:0] Instr_D;
    logic [31:0] PC_D4;
    logic        cmp_eq_D;
    logic        Bcd_cmp_D;
    logic [31:0] rs_D;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] PC_F;
    logic [31:0] Instr_F;
    logic        redirect_F;
    logic        pc_misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;

    modport master (
        output WE, pcSrc, Instr_D, PC_D4, cmp_eq_D, Bcd_cmp_D, rs_D, i_inst_rdata,
        input  i_inst_addr, PC_F, Instr_F, redirect_F, pc_misalign,
               fetch_cnt, stall_cnt, redirect_cnt
    );

    modport slave (
        input  WE, pcSrc, Instr_D, PC_D4, cmp_eq_D, Bcd_cmp_D, rs_D, i_inst_rdata,
        output i_inst_addr, PC_F, Instr_F, redirect_F, pc_misalign,
               fetch_cnt, stall_cnt, redirect_cnt
    );
endinterface

// File: rtl/pc_fetch.sv
// MIPS fetch stage: fetch PC, delayed-branch next-PC select, perf counters, sticky jr misalign flag.
// Latency: PC_F registered (1 cycle); address/instr/redirect combinational. Backpressure: WE=0 holds all but stall_cnt.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic       clk,
    input  logic       reset,
    pc_fetch_if.slave  bus
);

    typedef enum logic [2:0] {
        SRC_SEQ = 3'b000,
        SRC_BEQ = 3'b001,
        SRC_JAL = 3'b010,
        SRC_JR  = 3'b011,
        SRC_BCD = 3'b100,
        SRC_BNE = 3'b101
    } pc_src_t;

    logic [31:0] pc_q;
    logic [31:0] fetch_q;
    logic [31:0] stall_q;
    logic [31:0] redir_q;
    logic        misalign_q;

    logic [15:0] imm16;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic        jr_misaligned;
    logic        unused_ok;

    assign imm16      = bus.Instr_D[15:0];
    assign branch_tgt = bus.PC_D4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_tgt   = {bus.PC_D4[31:28], bus.Instr_D[25:0], 2'b00};
    assign jr_tgt     = {bus.rs_D[31:2], 2'b00};
    assign seq_pc     = pc_q + 32'd4;

    // Opcode/funct bits are decoded upstream; only the target fields matter here.
    assign unused_ok = ^bus.Instr_D[31:26];

    always_comb begin
        redirect = 1'b0;
        next_pc  = seq_pc;
        case (pc_src_t'(bus.pcSrc))
            SRC_BEQ: redirect = bus.cmp_eq_D;
            SRC_BNE: redirect = ~bus.cmp_eq_D;
            SRC_BCD: redirect = bus.Bcd_cmp_D;
            SRC_JAL: redirect = 1'b1;
            SRC_JR:  redirect = 1'b1;
            default: redirect = 1'b0;
        endcase
        if (redirect) begin
            case (pc_src_t'(bus.pcSrc))
                SRC_JAL: next_pc = jump_tgt;
                SRC_JR:  next_pc = jr_tgt;
                default: next_pc = branch_tgt;
            endcase
        end
    end

    assign jr_misaligned = (bus.pcSrc == SRC_JR) && (bus.rs_D[1:0] != 2'b00);

    // A stalled cycle discards the decision; D re-presents it once WE returns.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            fetch_q    <= 32'd0;
            stall_q    <= 32'd0;
            redir_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else if (bus.WE) begin
            pc_q    <= next_pc;
            fetch_q <= fetch_q + 32'd1;
            if (redirect) begin
                redir_q <= redir_q + 32'd1;
            end
            if (jr_misaligned) begin
                misalign_q <= 1'b1;
            end
        end else begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.PC_F         = pc_q;
    assign bus.i_inst_addr  = pc_q;
    assign bus.Instr_F      = bus.i_inst_rdata;
    assign bus.redirect_F   = redirect;
    assign bus.pc_misalign  = misalign_q;
    assign bus.fetch_cnt    = fetch_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.redirect_cnt = redir_q;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the fetch PC, drives the instruction-memory address, and passes the fetched word forward to the IF/ID register. It computes the next PC from the D-stage control-flow decision (`pcSrc`, compare results, immediate/index fields) with delayed-branch semantics. It also keeps fetch, stall and redirect performance counters and a sticky misalignment flag.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  input  1  pipeline clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low; `reset==0` at a rising edge resets all state.
- `WE`  input  1  advance enable, the same stall signal that drives IF/ID `WE`; 0 = hold PC.
- `pcSrc`  input  3  D-stage control-flow select: 000 seq, 001 beq, 010 jal, 011 jr, 100 bcd, 101 bne; 110/111 are treated as 000.
- `Instr_D`  input  32  D-stage instruction; supplies imm16 [15:0] and index26 [25:0].
- `PC_D4`  input  32  PC of the D-stage instruction + 4.
- `cmp_eq_D`  input  1  forwarded rs==rt result for the D-stage instruction.
- `Bcd_cmp_D`  input  1  bcd condition result.
- `rs_D`  input  32  forwarded rs value (jr target).
- `i_inst_rdata`  input  32  word returned by instruction memory for `i_inst_addr`.
- `i_inst_addr`  output  32  instruction-memory address; equals `PC_F`.
- `PC_F`  output  32  current fetch PC.
- `Instr_F`  output  32  equals `i_inst_rdata`; combinational pass-through.
- `redirect_F`  output  1  combinational; 1 when the next PC is not `PC_F+4`.
- `pc_misalign`  output  1  sticky; set when a jr target has [1:0]≠0.
- `fetch_cnt`  output  32  cycles with `WE=1` since reset.
- `stall_cnt`  output  32  cycles with `WE=0` since reset.
- `redirect_cnt`  output  32  cycles with `WE=1 && redirect_F` since reset.

## Operation
- Branch target `bt = PC_D4 + {{14{imm16[15]}}, imm16, 2'b00}`, 32-bit wrap.
- Jump target `jt = {PC_D4[31:28], index26, 2'b00}`.
- Next PC selection:
  - 001 → `bt` if `cmp_eq_D`.
  - 101 → `bt` if `!cmp_eq_D`.
  - 100 → `bt` if `Bcd_cmp_D`.
  - 010 → `jt`.
  - 011 → `{rs_D[31:2], 2'b00}`.
  - Otherwise, and for an untaken branch → `PC_F + 4`.
- `redirect_F` = taken branch, or pcSrc 010/011.
- Delayed branch: the control-flow instruction sits in D while its delay slot is at `PC_F`. The target is fetched the cycle after the delay slot is fetched. No instruction is squashed here.
- jr misalignment: when `pcSrc==011 && WE && rs_D[1:0]!=0`:
  - `pc_misalign` is set to 1 and stays 1 until reset.
  - The PC still loads the forced-aligned target.
- Counters are 32-bit and wrap from FFFF_FFFF to 0. Exactly one of `fetch_cnt` and `stall_cnt` increments each non-reset cycle.

## Timing
- Reset (`reset==0` at edge) dominates `WE`. After reset:
  - `PC_F=RESET_PC`
  - `pc_misalign=0`
  - all counters 0
  - `i_inst_addr=RESET_PC`
- `PC_F` is registered, with 1-cycle latency from the next-PC decision. With `WE=1`, `PC_F` becomes the next PC at the edge.
- With `WE=0`, `PC_F` holds and the redirect decision is discarded. While stalled, D holds its instruction and operands, so the same decision is re-evaluated when `WE` returns.
- `i_inst_addr`, `Instr_F` and `redirect_F` are combinational with zero latency. The memory is read asynchronously in the same cycle.
- Counters update at the same edge as `PC_F` and use the pre-edge `WE`/`redirect_F`.
- Reset asserted mid-stall or mid-redirect: the next edge yields pure reset values, with no counter increment.
- PC wrap: `PC_F=FFFF_FFFC` sequential → `0000_0000`.

## Test plan
- Reset, then 4 cycles `WE=1`, pcSrc=000 → `PC_F` 3000,3004,3008,300C,3010; `fetch_cnt=4`, `stall_cnt=0`.
- `PC_D4=3008`, imm16=FFFE, pcSrc=001, `cmp_eq_D=1` → next `PC_F=3000`, `redirect_cnt+1`. Repeat with `cmp_eq_D=0` → `PC_F+4`. pcSrc=101 gives the inverse results.
- pcSrc=010, `PC_D4=3010`, index26=0000C40 → `PC_F=0000_3100`. pcSrc=011, `rs_D=0000_3202` → `PC_F=0000_3200`, `pc_misalign=1`, which persists through later cycles.
- pcSrc=001 taken with `WE=0` for 3 cycles, then `WE=1` → `PC_F` held 3 cycles then loads `bt`; `stall_cnt=3`, `redirect_cnt=1`.
- Reset asserted (0) for one edge during a taken jal with `WE=1` → `PC_F=3000`, all counters 0, flag cleared. Also check a bcd case: pcSrc=100 with `Bcd_cmp_D=0` → `PC_F+4`, `redirect_F=0`.
